// File: rtl/seq_detect_moore.sv
// seq_detect_moore: Moore serial pattern detector with KMP-style
// transition table, optional overlap, and saturating match counter.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   en        - bit-valid qualifier; din sampled only when en=1
//   din       - serial data bit (pattern MSB is received first)
//   clr       - synchronous clear of state and counter (beats en)
//   det       - high while in the MATCH state (decoded from state)
//   match_cnt - saturating count of completed matches
//   state     - number of pattern prefix bits currently matched
module seq_detect_moore #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8,
    parameter int               ST_W    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             det,
    output logic [CNT_W-1:0] match_cnt,
    output logic [ST_W-1:0]  state
);

    localparam logic [ST_W-1:0]  ST_IDLE  = '0;
    localparam logic [ST_W-1:0]  ST_MATCH = ST_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Longest pattern prefix that is a suffix of (first k pattern bits, b).
    // Evaluated only at elaboration to build the transition table.
    function automatic int next_k(input int k, input bit b);
        int  res;
        int  lim;
        int  idx;
        bit  ok;
        bit  sb;
        res = 0;
        if (!OVERLAP && k == PAT_W) begin
            res = (b == PATTERN[PAT_W-1]) ? 1 : 0;
        end else begin
            lim = (k + 1 < PAT_W) ? k + 1 : PAT_W;
            // Ascending scan: the last j that fits is the longest.
            for (int j = 1; j <= lim; j++) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    idx = k + 1 - j + i;
                    if (idx == k)
                        sb = b;
                    else
                        sb = PATTERN[PAT_W-1-idx];
                    if (sb != PATTERN[PAT_W-1-i])
                        ok = 1'b0;
                end
                if (ok)
                    res = j;
            end
        end
        return res;
    endfunction

    logic [ST_W-1:0] tbl0 [0:PAT_W];
    logic [ST_W-1:0] tbl1 [0:PAT_W];

    for (genvar k = 0; k <= PAT_W; k++) begin : g_tbl
        localparam int N0 = next_k(k, 1'b0);
        localparam int N1 = next_k(k, 1'b1);
        assign tbl0[k] = ST_W'(N0);
        assign tbl1[k] = ST_W'(N1);
    end

    logic [ST_W-1:0]  step;
    logic [ST_W-1:0]  state_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Table lookup; any unreachable encoding falls back to idle.
    always_comb begin
        step = ST_IDLE;
        for (int k = 0; k <= PAT_W; k++) begin
            if (state == ST_W'(k))
                step = din ? tbl1[k] : tbl0[k];
        end
    end

    // Entering MATCH, or a MATCH self-loop, both complete one match.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = match_cnt;
        if (clr) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if (en) begin
            state_nxt = step;
            if (step == ST_MATCH && match_cnt != CNT_MAX)
                cnt_nxt = match_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
        end else begin
            state     <= state_nxt;
            match_cnt <= cnt_nxt;
        end
    end

    assign det = (state == ST_MATCH);

endmodule

// File: tb/tb_seq_detect_moore.sv
// tb_seq_detect_moore: scoreboard bench for four detector variants
// driven by a shared stimulus stream.
module tb_seq_detect_moore;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic din = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    logic       det0, det1, det2, det3;
    logic [2:0] st0, st1, st2;
    logic [1:0] st3;
    logic [7:0] cnt0, cnt1, cnt3;
    logic [1:0] cnt2;

    seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1),
                       .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .det(det0), .match_cnt(cnt0), .state(st0));

    seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0),
                       .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .det(det1), .match_cnt(cnt1), .state(st1));

    seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1),
                       .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .det(det2), .match_cnt(cnt2), .state(st2));

    seq_detect_moore #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1),
                       .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .det(det3), .match_cnt(cnt3), .state(st3));

    typedef struct {
        string tag;
        int    idx;
        int    st;
        int    dt;
        int    cn;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    // Reference model: raw bit history, state = longest history suffix
    // that equals a pattern prefix.
    int          pw   [4] = '{4, 4, 4, 3};
    int          pat  [4] = '{11, 11, 11, 7};
    bit          ov   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          cmax [4] = '{255, 255, 3, 255};
    int          mk   [4];
    int          mc   [4];
    int          hn   [4];
    int          hv   [4];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic int obs_st(input int i);
        case (i)
            0: return int'(st0);
            1: return int'(st1);
            2: return int'(st2);
            default: return int'(st3);
        endcase
    endfunction

    function automatic int obs_det(input int i);
        case (i)
            0: return int'(det0);
            1: return int'(det1);
            2: return int'(det2);
            default: return int'(det3);
        endcase
    endfunction

    function automatic int obs_cnt(input int i);
        case (i)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    function automatic int kcalc(input int i);
        int res;
        int mask;
        res = 0;
        for (int j = 1; j <= pw[i]; j++) begin
            mask = (1 << j) - 1;
            if (j <= hn[i] && (hv[i] & mask) == (pat[i] >> (pw[i] - j)))
                res = j;
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mk[i] = 0;
            mc[i] = 0;
            hn[i] = 0;
            hv[i] = 0;
        end
    endtask

    task automatic model_edge(input bit e, input bit b, input bit c);
        if (c) begin
            model_reset();
        end else if (e) begin
            for (int i = 0; i < 4; i++) begin
                if (!ov[i] && mk[i] == pw[i]) begin
                    hv[i] = 0;
                    hn[i] = 0;
                end
                hv[i] = ((hv[i] << 1) | int'(b)) & 16'hffff;
                if (hn[i] < 16)
                    hn[i]++;
                mk[i] = kcalc(i);
                if (mk[i] == pw[i] && mc[i] < cmax[i])
                    mc[i]++;
            end
        end
    endtask

    task automatic push_all(input string tag);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.tag = tag;
            e.idx = i;
            e.st  = mk[i];
            e.dt  = (mk[i] == pw[i]) ? 1 : 0;
            e.cn  = mc[i];
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t  e;
        string t;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            t = $sformatf("%s.u%0d", e.tag, e.idx);
            chk({t, ".state"}, obs_st(e.idx), e.st);
            chk({t, ".det"}, obs_det(e.idx), e.dt);
            chk({t, ".cnt"}, obs_cnt(e.idx), e.cn);
        end
    endtask

    task automatic drive(input bit e, input bit b, input bit c,
                         input string tag);
        @(negedge clk);
        en  = e;
        din = b;
        clr = c;
        model_edge(e, b, c);
        push_all(tag);
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        logic [6:0] s7;
        logic [5:0] s6;
        logic [3:0] s4;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        push_all("rst");
        drain();
        @(negedge clk);
        rst = 1'b0;

        s7 = 7'b1011011;
        for (int i = 6; i >= 0; i--)
            drive(1'b1, s7[i], 1'b0, $sformatf("ov%0d", 7 - i));

        drive(1'b0, 1'b0, 1'b1, "clr0");

        s6 = 6'b101011;
        for (int i = 5; i >= 0; i--)
            drive(1'b1, s6[i], 1'b0, $sformatf("kmp%0d", 6 - i));

        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'(i), 1'b0, $sformatf("hold%0d", i));

        drive(1'b1, 1'b1, 1'b1, "clr_pri");

        s4 = 4'b1011;
        for (int m = 0; m < 5; m++)
            for (int i = 3; i >= 0; i--)
                drive(1'b1, s4[i], 1'b0, $sformatf("sat%0d", m));

        drive(1'b1, 1'b1, 1'b0, "ones0");
        drive(1'b1, 1'b1, 1'b0, "ones1");
        drive(1'b1, 1'b1, 1'b0, "ones2");

        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 60) == 0, $sformatf("rnd%0d", i));

        drive(1'b0, 1'b0, 1'b1, "clr1");
        drive(1'b1, 1'b1, 1'b0, "pre0");
        drive(1'b1, 1'b0, 1'b0, "pre1");

        // Between edges: reset must act with no clock edge.
        rst = 1'b1;
        #1;
        model_reset();
        push_all("arst");
        drain();
        #2;
        rst = 1'b0;

        drive(1'b1, 1'b1, 1'b0, "post0");
        drive(1'b1, 1'b0, 1'b0, "post1");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
